btn_cond: RTL and testbench

Button conditioner for the clock-setting front end. Takes the three raw, asynchronous, bouncing push-button levels (mode, select, adjust), synchronizes and debounces each, and produces clean single-cycle `MODE`, `SELECT` and `ADJUST` pulses for the time-setting state machine directly downstream. It guarantees at most one pulse per cycle. It can optionally auto-repeat `ADJUST` while the button is held.

---
 rtl/clock_pkg.sv | 32 +++
 rtl/btn_debounce.sv | 57 +++++
 rtl/btn_cond.sv | 125 ++++++++++++
 tb/tb_btn_cond.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | clock_pkg                                                                |
// | Shared types and defaults for the clock-setting button front end.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package clock_pkg;

  typedef enum logic [1:0] {
    BTN_MODE   = 2'd0,
    BTN_SELECT = 2'd1,
    BTN_ADJUST = 2'd2
  } btn_idx_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rep_state_e;

  localparam int C_NUM_BTN        = 3;
  localparam int C_DEB_CYC_DEF    = 500000;
  localparam int C_REPEAT_DLY_DEF = 25000000;
  localparam int C_REPEAT_PER_DEF = 5000000;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | btn_debounce                                                             |
// | Two-flop synchronizer plus stable-count debouncer for one button; emits |
// | the debounced level and a one-cycle strobe on each accepted press.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module btn_debounce
  import clock_pkg::*;
#(
  parameter int DEB_CYC = C_DEB_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_deb,
  output logic o_rise
);

  localparam int             CW     = cnt_width(DEB_CYC);
  localparam logic [CW-1:0]  C_LAST = CW'(DEB_CYC - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_deb;
  logic          r_rise;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_deb  <= 1'b0;
      r_rise <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= i_raw;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      // Any sample agreeing with the current level restarts the stability count.
      if (r_s2 == r_deb) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        r_deb  <= r_s2;
        r_rise <= r_s2;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_deb  = r_deb;
  assign o_rise = r_rise;

endmodule
`default_nettype wire

// File: rtl/btn_cond.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | btn_cond                                                                 |
// | Debounces mode/select/adjust buttons and issues prioritised one-cycle   |
// | pulses. Define BTN_REPEAT_EN to add auto-repeat on ADJUST while held.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module btn_cond
  import clock_pkg::*;
#(
  parameter int DEB_CYC    = C_DEB_CYC_DEF,
  parameter int REPEAT_DLY = C_REPEAT_DLY_DEF,
  parameter int REPEAT_PER = C_REPEAT_PER_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_mode_raw,
  input  logic btn_select_raw,
  input  logic btn_adjust_raw,
  output logic MODE,
  output logic SELECT,
  output logic ADJUST
);

  logic [C_NUM_BTN-1:0] w_raw;
  logic [C_NUM_BTN-1:0] w_deb;
  logic [C_NUM_BTN-1:0] w_rise;
  logic                 w_rep;
  logic                 w_cand_mode;
  logic                 w_cand_select;
  logic                 w_cand_adjust;
  logic                 w_unused;

  assign w_raw[BTN_MODE]   = btn_mode_raw;
  assign w_raw[BTN_SELECT] = btn_select_raw;
  assign w_raw[BTN_ADJUST] = btn_adjust_raw;

  for (genvar gi = 0; gi < C_NUM_BTN; gi++) begin : g_btn
    btn_debounce #(
      .DEB_CYC (DEB_CYC)
    ) u_debounce (
      .clk    (clk),
      .rst    (rst),
      .i_raw  (w_raw[gi]),
      .o_deb  (w_deb[gi]),
      .o_rise (w_rise[gi])
    );
  end

`ifdef BTN_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int RW      = cnt_width(REP_MAX);
  localparam logic [RW-1:0] C_DLY_LAST = RW'(REPEAT_DLY - 1);
  localparam logic [RW-1:0] C_PER_LAST = RW'(REPEAT_PER - 1);

  rep_state_e    r_rep_state;
  logic [RW-1:0] r_rep_cnt;

  // Repeat candidates are qualified by the live level so a release cuts them off at once.
  assign w_rep = w_deb[BTN_ADJUST] &&
                 (((r_rep_state == DELAY)  && (r_rep_cnt == C_DLY_LAST)) ||
                  ((r_rep_state == REPEAT) && (r_rep_cnt == C_PER_LAST)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rep_state <= IDLE;
      r_rep_cnt   <= '0;
    end else if (!w_deb[BTN_ADJUST]) begin
      r_rep_state <= IDLE;
      r_rep_cnt   <= '0;
    end else begin
      case (r_rep_state)
        IDLE: begin
          if (w_rise[BTN_ADJUST]) begin
            r_rep_state <= DELAY;
            r_rep_cnt   <= '0;
          end
        end
        DELAY: begin
          if (r_rep_cnt == C_DLY_LAST) begin
            r_rep_state <= REPEAT;
            r_rep_cnt   <= '0;
          end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (r_rep_cnt == C_PER_LAST) begin
            r_rep_cnt <= '0;
          end else begin
            r_rep_cnt <= r_rep_cnt + 1'b1;
          end
        end
        default: begin
          r_rep_state <= IDLE;
          r_rep_cnt   <= '0;
        end
      endcase
    end
  end
`else
  assign w_rep = 1'b0;
`endif

  assign w_unused = ^{w_deb, REPEAT_DLY[0], REPEAT_PER[0]};

  assign w_cand_mode   = w_rise[BTN_MODE];
  assign w_cand_select = w_rise[BTN_SELECT];
  assign w_cand_adjust = w_rise[BTN_ADJUST] | w_rep;

  // Fixed priority; losers are dropped rather than queued.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      MODE   <= 1'b0;
      SELECT <= 1'b0;
      ADJUST <= 1'b0;
    end else begin
      MODE   <= w_cand_mode;
      SELECT <= w_cand_select & ~w_cand_mode;
      ADJUST <= w_cand_adjust & ~w_cand_mode & ~w_cand_select;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_cond.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_btn_cond                                                              |
// | Directed plus random stimulus against a sample-history reference model. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_btn_cond;

  localparam int DEB  = 4;
  localparam int DLY  = 20;
  localparam int PER  = 8;
  localparam int MAXN = 4096;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic bm  = 1'b0;
  logic bs  = 1'b0;
  logic ba  = 1'b0;
  logic o_mode, o_select, o_adjust;

  btn_cond #(
    .DEB_CYC    (DEB),
    .REPEAT_DLY (DLY),
    .REPEAT_PER (PER)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .btn_mode_raw   (bm),
    .btn_select_raw (bs),
    .btn_adjust_raw (ba),
    .MODE           (o_mode),
    .SELECT         (o_select),
    .ADJUST         (o_adjust)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cnt_m, cnt_s, cnt_a;

  // Raw level seen at each edge since reset release, and debounced level after it.
  bit rawh [3][MAXN];
  bit dh   [3][MAXN];
  int lastp[3];
  int n = 0;

  function automatic bit raw_at(input int b, input int i);
    return (i < 1) ? 1'b0 : rawh[b][i];
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, n, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step(input bit m, input bit s, input bit a, input bit r);
    bit press[3];
    bit rep, em, es, ea, v, alleq;
    @(negedge clk);
    bm = m; bs = s; ba = a; rst = r;
    @(posedge clk);
    em = 0; es = 0; ea = 0;
    if (r) begin
      n = 0;
      for (int b = 0; b < 3; b++) begin
        dh[b][0] = 1'b0;
        lastp[b] = -1;
      end
    end else begin
      n++;
      rawh[0][n] = m; rawh[1][n] = s; rawh[2][n] = a;
      for (int b = 0; b < 3; b++)
        press[b] = (n >= 2) && dh[b][n-1] && !dh[b][n-2];
      rep = 1'b0;
`ifdef BTN_REPEAT_EN
      if (lastp[2] >= 0 && dh[2][n-1]) begin
        int age;
        age = n - 1 - lastp[2];
        if (age >= DLY && ((age - DLY) % PER) == 0) rep = 1'b1;
      end
`endif
      em = press[0];
      es = press[1] && !em;
      ea = (press[2] || rep) && !em && !es;
      // Level is accepted once the two-cycle-delayed input has held it for DEB samples.
      for (int b = 0; b < 3; b++) begin
        v = raw_at(b, n - 2);
        alleq = 1'b1;
        for (int k = 0; k < DEB; k++)
          if (raw_at(b, n - 2 - k) != v) alleq = 1'b0;
        dh[b][n] = alleq ? v : dh[b][n-1];
        if (dh[b][n] && !dh[b][n-1]) lastp[b] = n;
        else if (!dh[b][n]) lastp[b] = -1;
      end
    end
    #1;
    check_bit("MODE", o_mode, em);
    check_bit("SELECT", o_select, es);
    check_bit("ADJUST", o_adjust, ea);
    cnt_m += int'(o_mode === 1'b1);
    cnt_s += int'(o_select === 1'b1);
    cnt_a += int'(o_adjust === 1'b1);
  endtask

  task automatic hold(input bit m, input bit s, input bit a, input int len);
    repeat (len) step(m, s, a, 1'b0);
  endtask

  task automatic do_reset(input int len);
    repeat (len) step(1'b0, 1'b0, 1'b0, 1'b1);
    cnt_m = 0; cnt_s = 0; cnt_a = 0;
  endtask

  task automatic count_check(input string tag, input int em, input int es, input int ea);
    check_int({tag, "_mode_pulses"}, cnt_m, em);
    check_int({tag, "_select_pulses"}, cnt_s, es);
    check_int({tag, "_adjust_pulses"}, cnt_a, ea);
    cnt_m = 0; cnt_s = 0; cnt_a = 0;
  endtask

  initial begin
    bit m, s, a;
    int len;
    cnt_m = 0; cnt_s = 0; cnt_a = 0;

    do_reset(3);

    // Clean mode press held 40 cycles, then released.
    hold(1, 0, 0, 40);
    hold(0, 0, 0, 15);
    count_check("clean_mode", 1, 0, 0);

    // Select bounce pattern followed by a short glitch, then a clean press.
    step(0, 1, 0, 0); step(0, 0, 0, 0); step(0, 1, 0, 0); step(0, 0, 0, 0);
    hold(0, 1, 0, 3);
    hold(0, 0, 0, 10);
    count_check("select_glitch", 0, 0, 0);
    hold(0, 1, 0, 10);
    hold(0, 0, 0, 15);
    count_check("select_clean", 0, 1, 0);

    // Mode and adjust together: mode wins, adjust is dropped.
    hold(1, 0, 1, 10);
    hold(0, 0, 0, 15);
    count_check("mode_vs_adjust", 1, 0, 0);

    // Reset asserted mid-debounce of a held select press.
    do_reset(2);
    hold(0, 1, 0, 4);
    repeat (4) step(0, 1, 0, 1);
    cnt_m = 0; cnt_s = 0; cnt_a = 0;
    hold(0, 1, 0, 20);
    hold(0, 0, 0, 15);
    count_check("reset_mid_press", 0, 1, 0);

    // Adjust held for 60 cycles.
    do_reset(2);
    hold(0, 0, 1, 60);
    hold(0, 0, 0, 15);
`ifdef BTN_REPEAT_EN
    count_check("adjust_hold", 0, 0, 6);
`else
    count_check("adjust_hold", 0, 0, 1);
`endif

    // Random levels with occasional bounces and resets.
    for (int seg = 0; seg < 40; seg++) begin
      m = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      a = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 40);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 99) < 2) begin
          step(m, s, a, 1'b1);
        end else begin
          step(m ^ ($urandom_range(0, 9) == 0),
               s ^ ($urandom_range(0, 9) == 0),
               a ^ ($urandom_range(0, 9) == 0), 1'b0);
        end
      end
    end
    hold(0, 0, 0, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
